// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Main sequencer for the multicycle RV32I core. Drives every enable
//            and mux select of the shared-ALU / unified-memory datapath.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

  state_t r_state;
  logic   r_illegal;
  logic   w_ready;

  assign w_ready = USE_MEM_READY ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:    if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            C_OP_LOAD, C_OP_STORE: r_state <= S_MEMADR;
            C_OP_RTYPE:            r_state <= S_EXECR;
            C_OP_ITYPE:            r_state <= S_EXECI;
            C_OP_JAL:              r_state <= S_JAL;
            C_OP_BRANCH:           r_state <= S_BEQ;
            default: begin
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   r_state <= (op == C_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (w_ready) r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        S_BEQ:      r_state <= S_FETCH;
        S_TRAP:     r_state <= S_TRAP;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // During reset the selects decode as FETCH and all write enables are masked.
  state_t     w_st;
  logic [1:0] w_alu_op;
  logic       w_pc_write;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;

  always_comb begin
    w_st        = rst ? S_FETCH : r_state;
    w_alu_op    = 2'b00;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    case (w_st)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = w_ready;
        w_pc_write = w_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        w_alu_op  = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_alu_op  = 2'b10;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        w_alu_op   = 2'b01;
        w_pc_write = zero;
      end
      default: ;
    endcase

    pc_write  = w_pc_write  & ~rst;
    mem_write = w_mem_write & ~rst;
    ir_write  = w_ir_write  & ~rst;
    reg_write = w_reg_write & ~rst;
  end

  always_comb begin
    alu_control = 3'b000;
    case (w_alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      C_OP_STORE:  imm_src = 2'b01;
      C_OP_BRANCH: imm_src = 2'b10;
      C_OP_JAL:    imm_src = 2'b11;
      default:     imm_src = 2'b00;
    endcase
  end

  assign illegal = r_illegal;
  assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Purpose  : Directed per-cycle vectors queued as expectations, popped and
//            compared against all DUT outputs on each falling edge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state;

  multicycle_control_fsm #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [20:0] v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  exp_t m_e;

  // {state, pc_write, adr_src, mem_write, ir_write, reg_write, illegal,
  //  result_src, alu_src_a, alu_src_b, alu_control, imm_src}
  logic [20:0] act;
  assign act = {state, pc_write, adr_src, mem_write, ir_write, reg_write, illegal,
                result_src, alu_src_a, alu_src_b, alu_control, imm_src};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      n_vec++;
      if (act !== m_e.v) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", m_e.nm, act, m_e.v);
      end
    end
  end

  task automatic ins(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  // wr = {pc_write, adr_src, mem_write, ir_write, reg_write, illegal}
  task automatic cyc(input string nm, input logic r, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [5:0] wr, input logic [1:0] rs,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ac,
                     input logic [1:0] im);
    exp_t e;
    rst = r; zero = z; mem_ready = rdy;
    e.nm = nm;
    e.v  = {st, wr, rs, sa, sb, ac, im};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    ins(7'b0110011, 3'b000, 1'b0);
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst0",    1,0,1, 4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("rst1",    1,0,1, 4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    // add
    cyc("add_f",   0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("add_d",   0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc("add_x",   0,0,1, 4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00);
    cyc("add_wb",  0,0,1, 4'd7, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    // sub
    ins(7'b0110011, 3'b000, 1'b1);
    cyc("sub_f",   0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("sub_d",   0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc("sub_x",   0,0,1, 4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00);
    cyc("sub_wb",  0,0,1, 4'd7, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    // slt
    ins(7'b0110011, 3'b010, 1'b0);
    cyc("slt_f",   0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("slt_d",   0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc("slt_x",   0,0,1, 4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00);
    cyc("slt_wb",  0,0,1, 4'd7, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    // addi with IR[30] set must still add (op[5]=0)
    ins(7'b0010011, 3'b000, 1'b1);
    cyc("addi_f",  0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("addi_d",  0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc("addi_x",  0,0,1, 4'd8, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    cyc("addi_wb", 0,0,1, 4'd7, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    // ori, andi
    ins(7'b0010011, 3'b110, 1'b0);
    cyc("ori_f",   0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("ori_d",   0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc("ori_x",   0,0,1, 4'd8, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b011, 2'b00);
    cyc("ori_wb",  0,0,1, 4'd7, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    ins(7'b0010011, 3'b111, 1'b0);
    cyc("andi_f",  0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("andi_d",  0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc("andi_x",  0,0,1, 4'd8, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b010, 2'b00);
    cyc("andi_wb", 0,0,1, 4'd7, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    // lw with a fetch stall and a read stall
    ins(7'b0000011, 3'b010, 1'b0);
    cyc("lw_fst",  0,0,0, 4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("lw_f",    0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("lw_d",    0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    cyc("lw_ma",   0,0,1, 4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    cyc("lw_rst",  0,0,0, 4'd3, 6'b010000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    cyc("lw_rd",   0,0,1, 4'd3, 6'b010000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    cyc("lw_wb",   0,0,1, 4'd4, 6'b000010, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00);
    // sw with three wait cycles in MEMWRITE
    ins(7'b0100011, 3'b010, 1'b0);
    cyc("sw_f",    0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    cyc("sw_d",    0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01);
    cyc("sw_ma",   0,0,1, 4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01);
    cyc("sw_w0",   0,0,0, 4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    cyc("sw_w1",   0,0,0, 4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    cyc("sw_w2",   0,0,0, 4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    cyc("sw_w3",   0,0,1, 4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    // beq taken, then not taken
    ins(7'b1100011, 3'b000, 1'b0);
    cyc("beq1_f",  0,1,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10);
    cyc("beq1_d",  0,1,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10);
    cyc("beq1_b",  0,1,1, 4'd10,6'b100000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);
    cyc("beq0_f",  0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10);
    cyc("beq0_d",  0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10);
    cyc("beq0_b",  0,0,1, 4'd10,6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);
    // jal
    ins(7'b1101111, 3'b000, 1'b0);
    cyc("jal_f",   0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11);
    cyc("jal_d",   0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11);
    cyc("jal_j",   0,0,1, 4'd9, 6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11);
    cyc("jal_wb",  0,0,1, 4'd7, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11);
    // reset in the middle of a store abandons it
    ins(7'b0100011, 3'b010, 1'b0);
    cyc("swr_f",   0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    cyc("swr_d",   0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01);
    cyc("swr_ma",  0,0,1, 4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01);
    cyc("swr_w",   0,0,0, 4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    cyc("swr_rst", 1,0,1, 4'd5, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    // illegal opcode traps and stays until reset
    ins(7'b1111111, 3'b000, 1'b0);
    cyc("ill_f",   0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("ill_d",   0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    for (int i = 0; i < 10; i++)
      cyc("trap",  0,1,1, 4'd11,6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    cyc("trap_rst",1,1,1, 4'd11,6'b000001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    ins(7'b0110011, 3'b000, 1'b0);
    cyc("post_f",  0,0,1, 4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    cyc("post_d",  0,0,1, 4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
